pwm_ramp_ctrl: RTL and testbench
================================

Name: pwm_ramp_ctrl

Overview:
Sequencer that drives the configuration inputs of the team's 8-bit set/clear PWM generator: reload (period), set threshold and clear threshold. Given a target duty, step size and dwell count, it ramps the duty from its current level to the target, one step per dwell interval. It updates thresholds only on PWM period boundaries, so the generator never sees a mid-period change. It sits between a register/command front-end and the PWM instance, and reports completion with a ready/busy/done handshake.

Parameters:
WIDTH, 8, width of duty, period, step and dwell values; matches the PWM counter width.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start_i  input  1  command strobe; accepted only when ready_o=1
abort_i  input  1  stop the ramp and return to IDLE, holding the current level
target_i  input  WIDTH  target duty (high time in counts)
step_i  input  WIDTH  duty increment per step; 0 means jump to target in one step
dwell_i  input  WIDTH  each level is held for dwell_i+1 PWM periods
period_i  input  WIDTH  PWM reload value (counter runs 0..period_i)
period_tick_i  input  1  one-cycle pulse from the PWM datapath when its counter reloads to 0
ready_o  output  1  controller idle and able to accept start_i
busy_o  output  1  command in progress (equals ~ready_o)
done_o  output  1  one-cycle pulse when the target is reached
set_thres_o  output  WIDTH  to the PWM set threshold; constant 0
clr_thres_o  output  WIDTH  to the PWM clear threshold; equals the current duty
reload_o  output  WIDTH  to the PWM reload value
duty_o  output  WIDTH  current applied duty (mirror of clr_thres_o)

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, ready_o=1, busy_o=0, done_o=0, set_thres_o=0, clr_thres_o=0, reload_o=0, duty_o=0, all internal captures and counters 0.
- All outputs are registered. Every threshold change lands in the cycle after the period_tick_i sample that triggers it.
- States: IDLE, LOAD, RAMP, DONE.
- IDLE: ready_o=1. When start_i=1, capture the inputs:
  - tgt = min(target_i, period_i), per=period_i, stp = (step_i==0) ? per : step_i, dw = dwell_i.
  - Then go to LOAD.
  - start_i in any other state is ignored and not queued.
- LOAD: wait for period_tick_i. On the tick:
  - reload_o <= per.
  - cur = min(duty_o, per), written to clr_thres_o and duty_o.
  - dwell counter <= dw.
  - Go to DONE if cur==tgt, else go to RAMP.
- RAMP: on each period_tick_i:
  - If the dwell counter is not 0, decrement it.
  - Otherwise:
    - nxt = cur+stp saturated at tgt when cur<tgt; nxt = cur−stp saturated at tgt when cur>tgt. Compute in WIDTH+1 bits; no wrap or overshoot.
    - clr_thres_o and duty_o <= nxt; dwell counter <= dw.
    - If nxt==tgt, go to DONE.
- DONE: done_o=1 for exactly one cycle, then go to IDLE. Outputs keep their final values.
- abort_i=1 in LOAD, RAMP or DONE: go to IDLE next cycle. Thresholds hold their present values and done_o is not pulsed. abort_i wins over a simultaneous period_tick_i, and that tick applies no update. abort_i in IDLE has no effect.
- Duty semantics with set=0 and clr=duty: the output is high for duty counts per period. duty 0 gives constant low, because clear has priority. duty == per gives 100% minus the one clear cycle, which is accepted.
- Ticks in IDLE are ignored.
- Input ports are sampled only at start_i acceptance. Later changes do not affect the running command.
- rst mid-ramp: immediate return to the reset values above on that edge.

Test Plan:
- Up-ramp: reset, period_i=99, target_i=40, step_i=10, dwell_i=1, ticks every 100 cycles. Required: clr_thres_o steps 0→10→20→30→40, each level held 2 ticks, reload_o=99 from the first tick. done_o pulses once, then ready_o=1.
- Down-ramp with saturation: from duty 40, target_i=5, step_i=15, dwell_i=0. Required: 40→25→10→5, one tick per level, no underflow.
- Clamp and jump: period_i=50, target_i=200, step_i=0. Required: a single update to clr_thres_o=50 on the tick after LOAD, then done_o.
- Abort: abort_i asserted in the same cycle as a tick while ramping at duty 20. Required: duty stays 20, state IDLE, no done_o. A start_i during the ramp must be ignored.
- No-op command: target_i equal to the current duty. Required: on the first tick reload_o updates, clr_thres_o is unchanged, and done_o pulses.
- Reset mid-ramp: rst=1 while at duty 30. Required: all outputs 0 and ready_o=1 on the next edge. Ticks in IDLE change nothing.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_ctrl
// Brief    : Ramps the set/clear PWM duty toward a target in steps, updating
//            thresholds only on PWM period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_ramp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] target_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic [WIDTH-1:0] dwell_i,
    input  logic [WIDTH-1:0] period_i,
    input  logic             period_tick_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] set_thres_o,
    output logic [WIDTH-1:0] clr_thres_o,
    output logic [WIDTH-1:0] reload_o,
    output logic [WIDTH-1:0] duty_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RAMP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_tgt, w_tgt_nxt;
    logic [WIDTH-1:0] r_per, w_per_nxt;
    logic [WIDTH-1:0] r_stp, w_stp_nxt;
    logic [WIDTH-1:0] r_dw, w_dw_nxt;
    logic [WIDTH-1:0] r_dwell_cnt, w_dwell_cnt_nxt;
    logic [WIDTH-1:0] r_duty, w_duty_nxt;
    logic [WIDTH-1:0] r_reload, w_reload_nxt;
    logic             r_ready, r_busy, r_done;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_floor;
    logic [WIDTH-1:0] w_up_nxt, w_dn_nxt, w_ramp_nxt, w_load_cur, w_tgt_clamp;

    // Step arithmetic is one bit wider so the saturation test never wraps.
    assign w_sum       = {1'b0, r_duty} + {1'b0, r_stp};
    assign w_floor     = {1'b0, r_tgt} + {1'b0, r_stp};
    assign w_up_nxt    = (w_sum >= {1'b0, r_tgt}) ? r_tgt : w_sum[WIDTH-1:0];
    assign w_dn_nxt    = ({1'b0, r_duty} <= w_floor) ? r_tgt : (r_duty - r_stp);
    assign w_ramp_nxt  = (r_duty < r_tgt) ? w_up_nxt : w_dn_nxt;
    assign w_load_cur  = (r_duty > r_per) ? r_per : r_duty;
    assign w_tgt_clamp = (target_i > period_i) ? period_i : target_i;

    always_comb begin
        w_state_nxt     = r_state;
        w_tgt_nxt       = r_tgt;
        w_per_nxt       = r_per;
        w_stp_nxt       = r_stp;
        w_dw_nxt        = r_dw;
        w_dwell_cnt_nxt = r_dwell_cnt;
        w_duty_nxt      = r_duty;
        w_reload_nxt    = r_reload;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_tgt_nxt   = w_tgt_clamp;
                    w_per_nxt   = period_i;
                    w_stp_nxt   = (step_i == '0) ? period_i : step_i;
                    w_dw_nxt    = dwell_i;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort_i) begin
                    w_state_nxt = S_IDLE;
                end else if (period_tick_i) begin
                    w_reload_nxt    = r_per;
                    w_duty_nxt      = w_load_cur;
                    w_dwell_cnt_nxt = r_dw;
                    w_state_nxt     = (w_load_cur == r_tgt) ? S_DONE : S_RAMP;
                end
            end
            S_RAMP: begin
                if (abort_i) begin
                    w_state_nxt = S_IDLE;
                end else if (period_tick_i) begin
                    if (r_dwell_cnt != '0) begin
                        w_dwell_cnt_nxt = r_dwell_cnt - c_one;
                    end else begin
                        w_duty_nxt      = w_ramp_nxt;
                        w_dwell_cnt_nxt = r_dw;
                        if (w_ramp_nxt == r_tgt) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tgt       <= '0;
            r_per       <= '0;
            r_stp       <= '0;
            r_dw        <= '0;
            r_dwell_cnt <= '0;
            r_duty      <= '0;
            r_reload    <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tgt       <= w_tgt_nxt;
            r_per       <= w_per_nxt;
            r_stp       <= w_stp_nxt;
            r_dw        <= w_dw_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
            r_duty      <= w_duty_nxt;
            r_reload    <= w_reload_nxt;
            r_ready     <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign ready_o     = r_ready;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign set_thres_o = '0;
    assign clr_thres_o = r_duty;
    assign duty_o      = r_duty;
    assign reload_o    = r_reload;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_ramp_ctrl
// Brief    : Directed self-checking bench for pwm_ramp_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [7:0] target_i = '0;
    logic [7:0] step_i = '0;
    logic [7:0] dwell_i = '0;
    logic [7:0] period_i = '0;
    logic       period_tick_i = 1'b0;
    logic       ready_o, busy_o, done_o;
    logic [7:0] set_thres_o, clr_thres_o, reload_o, duty_o;

    int n_checks = 0;
    int n_pass   = 0;

    pwm_ramp_ctrl #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .target_i     (target_i),
        .step_i       (step_i),
        .dwell_i      (dwell_i),
        .period_i     (period_i),
        .period_tick_i(period_tick_i),
        .ready_o      (ready_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .set_thres_o  (set_thres_o),
        .clr_thres_o  (clr_thres_o),
        .reload_o     (reload_o),
        .duty_o       (duty_o)
    );

    always #5 clk = ~clk;

    // Inputs change on negedge; results are observed on the following negedge.
    task automatic send_cmd(input logic [7:0] tgt, input logic [7:0] stp,
                            input logic [7:0] dw, input logic [7:0] per);
        @(negedge clk);
        target_i = tgt; step_i = stp; dwell_i = dw; period_i = per;
        start_i  = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        target_i = 8'hEE; step_i = 8'h01; dwell_i = 8'h07; period_i = 8'hFF;
    endtask

    task automatic tick_after(input int gap);
        repeat (gap - 1) @(negedge clk);
        period_tick_i = 1'b1;
        @(negedge clk);
        period_tick_i = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({ready_o, busy_o, done_o} !== 3'b100) $display("FAIL reset_flags got=%b exp=100", {ready_o, busy_o, done_o});
        else n_pass++;
        n_checks++;
        if ({set_thres_o, clr_thres_o, reload_o, duty_o} !== 32'h0) $display("FAIL reset_values got=%h exp=0", {set_thres_o, clr_thres_o, reload_o, duty_o});
        else n_pass++;
    endtask

    task automatic test_up_ramp;
        logic [7:0] exp_duty [9] = '{8'd0, 8'd0, 8'd10, 8'd10, 8'd20, 8'd20, 8'd30, 8'd30, 8'd40};
        send_cmd(8'd40, 8'd10, 8'd1, 8'd99);
        n_checks++;
        if ({ready_o, busy_o} !== 2'b01) $display("FAIL up_busy got=%b exp=01", {ready_o, busy_o});
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            tick_after(100);
            n_checks++;
            if (clr_thres_o !== exp_duty[i] || duty_o !== exp_duty[i]) $display("FAIL up_duty tick=%0d got=%0d/%0d exp=%0d", i, clr_thres_o, duty_o, exp_duty[i]);
            else n_pass++;
            n_checks++;
            if (done_o !== (i == 8)) $display("FAIL up_done tick=%0d got=%b exp=%b", i, done_o, (i == 8));
            else n_pass++;
            n_checks++;
            if (reload_o !== 8'd99 || set_thres_o !== 8'd0) $display("FAIL up_reload tick=%0d got=%0d/%0d exp=99/0", i, reload_o, set_thres_o);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if ({done_o, ready_o, clr_thres_o} !== {1'b0, 1'b1, 8'd40}) $display("FAIL up_end got=%b/%b/%0d exp=0/1/40", done_o, ready_o, clr_thres_o);
        else n_pass++;
    endtask

    task automatic test_down_ramp;
        logic [7:0] exp_duty [4] = '{8'd40, 8'd25, 8'd10, 8'd5};
        send_cmd(8'd5, 8'd15, 8'd0, 8'd99);
        for (int i = 0; i < 4; i++) begin
            tick_after(4);
            n_checks++;
            if (duty_o !== exp_duty[i] || done_o !== (i == 3)) $display("FAIL down_step tick=%0d got=%0d/%b exp=%0d/%b", i, duty_o, done_o, exp_duty[i], (i == 3));
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if ({done_o, ready_o} !== 2'b01) $display("FAIL down_end got=%b exp=01", {done_o, ready_o});
        else n_pass++;
    endtask

    task automatic test_clamp_jump;
        send_cmd(8'd200, 8'd0, 8'd0, 8'd50);
        tick_after(4);
        n_checks++;
        if ({reload_o, clr_thres_o, done_o} !== {8'd50, 8'd5, 1'b0}) $display("FAIL clamp_load got=%0d/%0d/%b exp=50/5/0", reload_o, clr_thres_o, done_o);
        else n_pass++;
        tick_after(4);
        n_checks++;
        if ({clr_thres_o, done_o} !== {8'd50, 1'b1}) $display("FAIL clamp_jump got=%0d/%b exp=50/1", clr_thres_o, done_o);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_abort;
        send_cmd(8'd0, 8'd30, 8'd0, 8'd99);
        tick_after(4);
        n_checks++;
        if (duty_o !== 8'd50) $display("FAIL abort_load got=%0d exp=50", duty_o);
        else n_pass++;
        send_cmd(8'd99, 8'd1, 8'd0, 8'd99);  // must be ignored while ramping
        tick_after(4);
        n_checks++;
        if (duty_o !== 8'd20) $display("FAIL abort_ignore_start got=%0d exp=20", duty_o);
        else n_pass++;
        repeat (2) @(negedge clk);
        abort_i = 1'b1; period_tick_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0; period_tick_i = 1'b0;
        n_checks++;
        if ({duty_o, ready_o, busy_o, done_o} !== {8'd20, 3'b100}) $display("FAIL abort_hold got=%0d/%b exp=20/100", duty_o, {ready_o, busy_o, done_o});
        else n_pass++;
        tick_after(3);
        n_checks++;
        if ({duty_o, done_o, ready_o} !== {8'd20, 2'b01}) $display("FAIL abort_idle_tick got=%0d/%b exp=20/01", duty_o, {done_o, ready_o});
        else n_pass++;
    endtask

    task automatic test_noop;
        send_cmd(8'd20, 8'd5, 8'd2, 8'd60);
        tick_after(4);
        n_checks++;
        if ({reload_o, clr_thres_o, done_o} !== {8'd60, 8'd20, 1'b1}) $display("FAIL noop got=%0d/%0d/%b exp=60/20/1", reload_o, clr_thres_o, done_o);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({done_o, ready_o} !== 2'b01) $display("FAIL noop_end got=%b exp=01", {done_o, ready_o});
        else n_pass++;
    endtask

    task automatic test_reset_mid_ramp;
        send_cmd(8'd90, 8'd10, 8'd0, 8'd99);
        tick_after(4);
        tick_after(4);
        n_checks++;
        if (duty_o !== 8'd30) $display("FAIL midrst_pre got=%0d exp=30", duty_o);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({clr_thres_o, reload_o, duty_o, ready_o, busy_o, done_o} !== {24'h0, 3'b100}) $display("FAIL midrst got=%0d/%0d/%0d/%b exp=0/0/0/100", clr_thres_o, reload_o, duty_o, {ready_o, busy_o, done_o});
        else n_pass++;
        tick_after(3);
        n_checks++;
        if ({duty_o, reload_o, ready_o} !== {16'h0, 1'b1}) $display("FAIL midrst_idle_tick got=%0d/%0d/%b exp=0/0/1", duty_o, reload_o, ready_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_up_ramp();
        test_down_ramp();
        test_clamp_jump();
        test_abort();
        test_noop();
        test_reset_mid_ramp();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
